// File: rtl/ext_pkg.sv
// Shared definitions for the immediate / load-data extender family.
// Used by the decoder, the M-stage load path and the buffered extender.
package ext_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO   = 3'd0;
  localparam ext_mode_t EXT_SIGN   = 3'd1;
  localparam ext_mode_t EXT_HIGH   = 3'd2;
  localparam ext_mode_t EXT_BYTE_S = 3'd3;
  localparam ext_mode_t EXT_BYTE_U = 3'd4;
  localparam ext_mode_t EXT_HALF_S = 3'd5;
  localparam ext_mode_t EXT_HALF_U = 3'd6;
  localparam ext_mode_t EXT_PASS   = 3'd7;

endpackage

// File: rtl/ext_core.sv
// Purely combinational extender: immediate zero/sign/upper extension and
// offset-selected byte/half load extension. Misaligned halfword accesses
// report err and return zero.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = 2
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [IMM_W-1:0] imm;
  logic [7:0]       byte_val;
  logic [15:0]      half_val;
  logic [OFF_W-1:0] half_off;

  assign imm      = data[IMM_W-1:0];
  // Halfword lane is chosen by the offset with its low bit cleared, which
  // keeps the select generic for any OFF_W.
  assign half_off = off & ~OFF_W'(1);
  assign byte_val = 8'(data >> {off, 3'b000});
  assign half_val = 16'(data >> {half_off, 3'b000});

  // Select the extension requested by mode; everything defaults to zero/no-error.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (mode)
      EXT_ZERO:   result = DATA_W'(imm);
      EXT_SIGN:   result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_HIGH:   result = DATA_W'(imm) << IMM_W;
      EXT_BYTE_S: result = {{(DATA_W-8){byte_val[7]}}, byte_val};
      EXT_BYTE_U: result = DATA_W'(byte_val);
      EXT_HALF_S: begin
        if (off[0]) err = 1'b1;
        else        result = {{(DATA_W-16){half_val[15]}}, half_val};
      end
      EXT_HALF_U: begin
        if (off[0]) err = 1'b1;
        else        result = DATA_W'(half_val);
      end
      EXT_PASS:   result = data;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Buffered extender: ext_core followed by a one-entry output stage and a
// one-entry skid register, with valid/ready handshake and synchronous flush.
// in_ready comes straight from the skid flop, so out_ready never reaches it
// combinationally.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [DATA_W-1:0] f_data;
  logic              f_err;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic              accept;
  logic              out_free;

  ext_core #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .OFF_W (OFF_W)
  ) u_core (
    .mode  (in_mode),
    .off   (in_off),
    .data  (in_data),
    .result(f_data),
    .err   (f_err)
  );

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  // The output stage can take a new value when it is empty or being drained.
  assign out_free = ~out_valid | out_ready;

  // Output stage: refill from the skid first, else from a fresh accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        out_err   <= skid_err;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= f_data;
        out_err   <= f_err;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Skid register: catches an accept while the output is stalled, empties when the output frees up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (skid_valid && out_free) begin
      skid_valid <= 1'b0;
    end else if (accept && !out_free) begin
      skid_valid <= 1'b1;
      skid_data  <= f_data;
      skid_err   <= f_err;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed vector table, hand-written
// back-pressure / flush / async-reset sequences, then randomized traffic
// compared against a FIFO-level reference model.
module tb_ext_pipe;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int OFF_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mode;
  logic [OFF_W-1:0]  in_off;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];
  logic [32:0] model_q [$];

  ext_pipe #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .OFF_W (OFF_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_off   (in_off),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference extension computed with plain arithmetic; returns {err, result}.
  function automatic logic [32:0] ref_ext(input logic [2:0] mode, input logic [1:0] off,
                                          input logic [31:0] data);
    logic [31:0] imm, b, h, r;
    logic        e;
    imm = data % 65536;
    b   = (data >> (8 * off)) % 256;
    h   = (data >> (8 * off)) % 65536;
    r   = 0;
    e   = 0;
    case (mode)
      3'd0: r = imm;
      3'd1: r = (imm >= 32768) ? imm - 65536 : imm;
      3'd2: r = imm * 65536;
      3'd3: r = (b >= 128) ? b - 256 : b;
      3'd4: r = b;
      3'd5: if (off % 2 == 1) e = 1; else r = (h >= 32768) ? h - 65536 : h;
      3'd6: if (off % 2 == 1) e = 1; else r = h;
      default: r = data;
    endcase
    return {e, r};
  endfunction

  task automatic applyStimulus(input logic v, input logic [2:0] m, input logic [1:0] o,
                               input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_mode   = m;
    in_off    = o;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
    vecs[1]  = '{3'd2, 2'd0, 32'h1234_80F7, 32'h80F7_0000, 1'b0};
    vecs[2]  = '{3'd0, 2'd0, 32'h1234_80F7, 32'h0000_80F7, 1'b0};
    vecs[3]  = '{3'd3, 2'd0, 32'h1234_80F7, 32'hFFFF_FFF7, 1'b0};
    vecs[4]  = '{3'd4, 2'd3, 32'h1234_80F7, 32'h0000_0012, 1'b0};
    vecs[5]  = '{3'd5, 2'd2, 32'h1234_80F7, 32'h0000_1234, 1'b0};
    vecs[6]  = '{3'd6, 2'd0, 32'h1234_80F7, 32'h0000_80F7, 1'b0};
    vecs[7]  = '{3'd5, 2'd1, 32'h1234_80F7, 32'h0000_0000, 1'b1};
    vecs[8]  = '{3'd4, 2'd1, 32'h1234_80F7, 32'h0000_0080, 1'b0};
    vecs[9]  = '{3'd7, 2'd3, 32'h1234_80F7, 32'h1234_80F7, 1'b0};
    vecs[10] = '{3'd6, 2'd3, 32'h1234_80F7, 32'h0000_0000, 1'b1};
    vecs[11] = '{3'd1, 2'd0, 32'h1234_7FFF, 32'h0000_7FFF, 1'b0};
    vecs[12] = '{3'd3, 2'd2, 32'h12B4_80F7, 32'hFFFF_FFB4, 1'b0};
    vecs[13] = '{3'd5, 2'd0, 32'h1234_80F7, 32'hFFFF_80F7, 1'b0};

    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_err", 32'(out_err), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    step();

    // Directed vectors, one per cycle with out_ready held high.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].mode, vecs[i].off, vecs[i].data, 1'b1, 1'b0);
      step();
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vecs[i].exp_err));
    end
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("idle out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: four offered requests, only two fit.
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hAAAA_0001, 1'b0, 1'b0);
    step();
    checkOutput("bp1 out_data", out_data, 32'hAAAA_0001);
    checkOutput("bp1 in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hAAAA_0002, 1'b0, 1'b0);
    step();
    checkOutput("bp2 out_data", out_data, 32'hAAAA_0001);
    checkOutput("bp2 in_ready", 32'(in_ready), 32'd0);
    for (int k = 3; k <= 4; k++) begin
      applyStimulus(1'b1, 3'd7, 2'd0, 32'hAAAA_0000 + 32'(k), 1'b0, 1'b0);
      step();
      checkOutput($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d out_data", k), out_data, 32'hAAAA_0001);
      checkOutput($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("bp drain1 out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp drain1 out_data", out_data, 32'hAAAA_0002);
    checkOutput("bp drain1 in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("bp drain2 out_valid", 32'(out_valid), 32'd0);

    // Flush with both stages full and a third request offered.
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hBBBB_0001, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hBBBB_0002, 1'b0, 1'b0);
    step();
    checkOutput("fl full in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hBBBB_0003, 1'b0, 1'b1);
    step();
    checkOutput("fl out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("fl after%0d out_valid", k), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between edges while stalled and full.
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hCCCC_0001, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 3'd7, 2'd0, 32'hCCCC_0002, 1'b0, 1'b0);
    step();
    #2 reset = 1'b1;
    #1;
    checkOutput("arst out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("arst idle out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 3'd1, 2'd0, 32'h0000_F00D, 1'b1, 1'b0);
    step();
    checkOutput("arst first out_valid", 32'(out_valid), 32'd1);
    checkOutput("arst first out_data", out_data, 32'hFFFF_F00D);
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("arst empty out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic against an in-order queue of at most two results.
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      @(posedge clk);
      if (flush) begin
        model_q.delete();
      end else begin
        logic acc;
        acc = in_valid && (model_q.size() < 2);
        if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_ext(in_mode, in_off, in_data));
      end
      #1;
      checkOutput("rand out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      checkOutput("rand in_ready", 32'(in_ready), 32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        checkOutput("rand out_data", out_data, model_q[0][31:0]);
        checkOutput("rand out_err", 32'(out_err), 32'(model_q[0][32]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised successor to the combinational immediate extender.
- Performs immediate extension (zero, sign, upper/lui) and load-data extension (byte/half, signed/unsigned, offset-selected).
- Output is registered behind a 2-entry skid buffer with valid/ready handshake and flush.
- Sits between the D/M-stage datapath and the next pipeline register, so extension no longer lies on the critical combinational path.

Parameters:
- DATA_W, 32, width of extended result and of load-data input; must be ≥ 2*IMM_W and a multiple of 8.
- IMM_W, 16, width of the immediate field taken from in_data[IMM_W-1:0].
- OFF_W, 2, width of the byte-offset input; must satisfy 2**OFF_W == DATA_W/8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered results.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- in_mode  input  3  0 ZERO, 1 SIGN, 2 HIGH, 3 BYTE_S, 4 BYTE_U, 5 HALF_S, 6 HALF_U, 7 PASS.
- in_off  input  OFF_W  byte offset for BYTE/HALF modes; ignored otherwise.
- in_data  input  DATA_W  immediate (low IMM_W bits) or aligned load word.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- out_data  output  DATA_W  extended result.
- out_err  output  1  misaligned HALF access (in_off[0]==1).

Behaviour:
- Reset (async, level) values: out_valid=0, out_data=0, out_err=0, skid empty, in_ready=1.
- Extension function f(mode, off, data), pure combinational:
  - ZERO: {0, data[IMM_W-1:0]}.
  - SIGN: replicate data[IMM_W-1].
  - HIGH: data[IMM_W-1:0] << IMM_W, zero-filled.
  - BYTE_S / BYTE_U: byte = data[8*off +: 8], then sign- or zero-extend.
  - HALF_S / HALF_U: half = data[16*off[OFF_W-1:1] +: 16], then sign- or zero-extend; if off[0]==1, err=1 and result=0.
  - PASS: data unchanged.
- err=0 for every mode except misaligned HALF.
- Handshake:
  - Transfer in on in_valid&in_ready.
  - Transfer out on out_valid&out_ready.
  - Latency: accepted request appears on out_* the next cycle when the output stage is empty or draining.
- Output stage holds one result.
- Skid register holds one result; it captures the accept when out_valid&~out_ready in the same cycle.
- in_ready = ~skid_full, registered; no combinational path from out_ready to in_ready.
- When the output drains and skid is full, skid moves to the output next cycle and skid empties.
- Simultaneous drain and accept with skid empty: new result goes straight to the output stage.
- Throughput: one result per cycle while out_ready=1.
- out_data/out_err must stay stable while out_valid&~out_ready.
- flush:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - A request accepted in the flush cycle is dropped; flush wins.
  - out_data retains its old value; don't-care when invalid.
- Reset mid-transfer: all buffered results lost; no spurious out_valid after deassertion.
- Mode 7 with any in_off: no error.

Decomposition:
- Shared package ext_pkg: 3-bit mode localparams (EXT_ZERO..EXT_PASS), MODE_W=3.
- The package is reused by the decoder and by the M-stage load path.
- One sub-module, ext_core: combinational f(mode, off, data) → {err, result}, parametrised by DATA_W/IMM_W/OFF_W.
- ext_core is reused stand-alone wherever no buffering is needed.
- ext_pipe instantiates ext_core once and holds only handshake/storage logic.

Test Plan:
- Reset, then mode SIGN, in_data=0x0000_8001, out_ready=1 → next cycle out_valid=1, out_data=0xFFFF_8001, out_err=0.
- Sweep in_data=0x1234_80F7:
  - HIGH → 0x80F7_0000.
  - ZERO → 0x0000_80F7.
  - BYTE_S off=0 → 0xFFFF_FFF7.
  - BYTE_U off=3 → 0x0000_0012.
  - HALF_S off=2 → 0x0000_1234.
  - HALF_U off=0 → 0x0000_80F7.
- HALF_S off=1 → out_err=1, out_data=0; BYTE_U off=1 → out_err=0, out_data=0x0000_0080.
- Back-pressure: stream 4 requests with out_ready=0 → 2 accepted, in_ready low from cycle 3, out_data stable; then raise out_ready → both delivered in order on consecutive cycles, in_ready returns high, no loss or duplicate.
- Flush with both stages full plus in_valid=1 → next cycle out_valid=0, in_ready=1, none of the three results ever emitted.
- Assert reset asynchronously mid-stream (between edges) → out_valid=0 and in_ready=1 immediately; after release, first output is the first post-reset request.
